seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the 7-segment scan driver. Samples the multiplexed seg/an/dp lines and rebuilds the four displayed digits, blank flags and decimal points.
- Used as an in-fabric self-check and readback block. It sits on the same clock as the display mux and taps its output pins.
- Publishes a frame only after it has been seen identical on consecutive full scans.

Parameters:
- SETTLE_CYC, 4: clock cycles the anode must hold steady before seg/dp are sampled. Valid range 1..255.
- CONFIRM, 2: number of consecutive identical frames required before the outputs update. Valid range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- seg_in  in  7  segment lines {g,f,e,d,c,b,a}, active-low
- an_in  in  4  anode lines, active-low; an_in[3] is the leftmost digit (mt), an_in[0] the rightmost (so)
- dp_in  in  1  decimal point, active-low
- digit  out  16  {d3,d2,d1,d0}, each a 4-bit code; 4'hF means blank or invalid
- blank  out  4  1 = that digit had all segments off
- dp_seen  out  4  1 = dp was lit while that digit was active
- frame_valid  out  1  one-cycle pulse when digit/blank/dp_seen update
- err_pattern  out  1  one-cycle pulse: undecodable segment pattern sampled
- err_anode  out  1  one-cycle pulse: more than one anode active

Behaviour:
- Reset values:
  - digit = 16'hFFFF, blank = 4'hF, dp_seen = 0
  - frame_valid = 0, err_* = 0
  - FSM state IDLE; capture mask, confirm count and shadow frames all cleared
- All inputs are double-flop synchronised first, adding 2 cycles of latency. All further timing is counted on the synchronised values.
- Anode classification each cycle:
  - none active: idle
  - exactly one active: that slot is selected
  - two or more active: err_anode pulses, and the FSM forces IDLE on the next cycle
- FSM:
  - IDLE: on one active anode, latch the slot index, load the settle counter, go to SETTLE.
  - SETTLE: count down while the anode is unchanged.
    - Anode change to another single slot: reload the counter and stay in SETTLE.
    - Anode goes to none, or multiple: go to IDLE.
    - Counter hits 0: sample seg/dp into slot, set its capture mask bit, go to HOLD.
  - HOLD: no further samples. Any anode change leaves HOLD (to SETTLE for another single slot, otherwise IDLE). The same slot is never sampled twice in one dwell.
- Decode:
  - Standard 0-9 active-low patterns map to 4'h0-4'h9.
  - All segments off maps to code F with blank=1.
  - Anything else maps to code F with blank=0, and err_pattern pulses in the sample cycle.
- A slot re-captured before the frame completes overwrites its earlier value (latest sample wins).
- Frame completion, when the capture mask reaches 4'hF:
  - Clear the mask.
  - Compare the captured frame {digit, blank, dp} against the previous complete frame.
  - Equal: confirm count += 1, saturating at CONFIRM. Different: confirm count = 1.
  - When the count reaches CONFIRM and the frame differs from the published outputs: update the outputs and pulse frame_valid in the cycle after completion.
  - Identical republication produces no frame_valid pulse.
- Completion in the same cycle as err_anode: the err_anode path wins and the frame is discarded (mask cleared).
- rst asserted mid-scan: all state returns to reset values in the next cycle, and no partial frame is published.
- Counter widths: settle counter 8 bits, confirm counter 4 bits. No wrap: both load or saturate and never roll over.

Optional Feature:
- Macro SEG_DECODE_HEX_EN.
- Defined: patterns for A,b,C,d,E,F decode to 4'hA-4'hE plus F.
  - Pattern F is then distinct from blank only via blank=0; the blank flag is authoritative.
- Undefined: those patterns raise err_pattern and decode to F with blank=0.

Decomposition:
- Shared package (seg_pkg):
  - SEG_PATTERN constants for 0-9 and A-F (active-low, g..a order)
  - BLANK_CODE = 4'hF
  - FSM state enum {IDLE, SETTLE, HOLD}
- Sub-module seg7_pattern_decode: combinational 7-bit pattern to {code[3:0], blank, invalid}. It honours SEG_DECODE_HEX_EN.
  - Kept separate so the display mux encoder can be cross-checked against it.
- Remaining FSM, mask and confirm logic stays in seg_scan_decoder.

Test Plan:
- Scan "12:34" with a 20-cycle dwell per digit, CONFIRM=2 → after the 2nd full scan: digit=16'h1234, blank=0, a single frame_valid pulse; a 3rd identical scan gives no pulse.
- Anode dwell of 3 cycles with SETTLE_CYC=4 → no samples and no frame_valid ever; outputs stay at reset values.
- Drive an_in=4'b0011 for 1 cycle mid-scan → err_anode pulses once, the current partial frame is discarded, and the next two clean scans publish normally.
- seg_in=7'b0000000 (all lit, "8") then 7'b1111110 (only a lit) on slot 0 → first gives code 8; second gives code F, blank=0, err_pattern pulse.
- Blinking minutes: alternate frames "05:17" and blank-blank-17 (mt/mo blank) → confirm resets each frame, no frame_valid after the initial publish with CONFIRM=2.
- Assert rst for 1 cycle while in SETTLE after 3 slots captured → all outputs return to reset values; the next 2 complete scans are required before frame_valid.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment patterns, blank code and scan-decoder FSM states.
package seg_pkg;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_PATTERN [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-low {g..a} pattern to digit code; A-F decode only with SEG_DECODE_HEX_EN.
module seg7_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       blank,
  output logic       invalid
);
`ifdef SEG_DECODE_HEX_EN
  localparam int NDEC = 16;
`else
  localparam int NDEC = 10;
`endif
  always_comb begin
    blank = pattern == SEG_BLANK;
    code = BLANK_CODE;
    invalid = !blank;
    for (int i = 0; i < NDEC; i++)
      if (pattern == SEG_PATTERN[i]) begin
        code = 4'(i);
        invalid = 1'b0;
      end
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the four scanned digits from seg/an/dp pins, publishing confirmed frames.
// Hex digits A-F are accepted when SEG_DECODE_HEX_EN is defined.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int CONFIRM = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  input  logic        dp_in,
  output logic [15:0] digit,
  output logic [3:0]  blank,
  output logic [3:0]  dp_seen,
  output logic        frame_valid,
  output logic        err_pattern,
  output logic        err_anode
);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] CONF_MAX = 4'(CONFIRM);
  logic [6:0] seg_m, seg_s;
  logic [3:0] an_m, an_s;
  logic dp_m, dp_s;
  always_ff @(posedge clk) begin
    if (rst) begin
      {seg_m, seg_s} <= '1;
      {an_m, an_s} <= '1;
      {dp_m, dp_s} <= '1;
    end else begin
      {seg_m, seg_s} <= {seg_in, seg_m};
      {an_m, an_s} <= {an_in, an_m};
      {dp_m, dp_s} <= {dp_in, dp_m};
    end
  end
  logic [3:0] act;
  logic one, multi;
  logic [1:0] idx;
  assign act = ~an_s;
  assign multi = |(act & (act - 4'd1));
  assign one = |act & !multi;
  assign idx = act[3] ? 2'd3 : act[2] ? 2'd2 : act[1] ? 2'd1 : 2'd0;
  logic [3:0] code;
  logic pat_blank, pat_invalid;
  seg7_pattern_decode u_dec (
    .pattern(seg_s),
    .code(code),
    .blank(pat_blank),
    .invalid(pat_invalid)
  );
  state_t state;
  logic [1:0] slot;
  logic [7:0] cnt;
  logic [3:0] mask, conf, conf_n;
  logic [15:0] cap_code;
  logic [3:0] cap_blank, cap_dp;
  logic [23:0] prev, frame, pub;
  logic sample;
  assign frame = {cap_code, cap_blank, cap_dp};
  assign pub = {digit, blank, dp_seen};
  assign conf_n = frame == prev ? (conf >= CONF_MAX ? CONF_MAX : conf + 4'd1) : 4'd1;
  assign sample = state == SETTLE && one && idx == slot && cnt == 8'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot <= '0;
      cnt <= '0;
      mask <= '0;
      conf <= '0;
      cap_code <= '0;
      cap_blank <= '0;
      cap_dp <= '0;
      prev <= '0;
      digit <= 16'hFFFF;
      blank <= 4'hF;
      dp_seen <= '0;
      frame_valid <= 1'b0;
      err_pattern <= 1'b0;
      err_anode <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err_pattern <= sample & pat_invalid;
      err_anode <= multi;
      if (multi) begin
        state <= IDLE;
        mask <= '0;
      end else begin
        unique case (state)
          IDLE: if (one) begin
            slot <= idx;
            cnt <= SETTLE_LOAD;
            state <= SETTLE;
          end
          SETTLE: if (!one) state <= IDLE;
            else if (idx != slot) begin
              slot <= idx;
              cnt <= SETTLE_LOAD;
            end else if (cnt == 8'd0) state <= HOLD;
            else cnt <= cnt - 8'd1;
          HOLD: if (!one) state <= IDLE;
            else if (idx != slot) begin
              slot <= idx;
              cnt <= SETTLE_LOAD;
              state <= SETTLE;
            end
          default: state <= IDLE;
        endcase
        if (sample) begin
          cap_code[{slot, 2'b00} +: 4] <= code;
          cap_blank[slot] <= pat_blank;
          cap_dp[slot] <= ~dp_s;
          mask[slot] <= 1'b1;
        end else if (mask == 4'hF) begin
          mask <= '0;
          prev <= frame;
          conf <= conf_n;
          if (conf_n == CONF_MAX && frame != pub) begin
            {digit, blank, dp_seen} <= frame;
            frame_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans with hand-computed frames for seg_scan_decoder.
module tb_seg_scan_decoder;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] seg_in = '1;
  logic [3:0] an_in = '1;
  logic dp_in = 1'b1;
  logic [15:0] digit;
  logic [3:0] blank, dp_seen;
  logic frame_valid, err_pattern, err_anode;
  int n_tests = 0, n_fail = 0;
  int fv_cnt = 0, ep_cnt = 0, ea_cnt = 0, fv0 = 0, ep0 = 0, ea0 = 0;
  localparam logic [6:0] P0 = 7'h40, P1 = 7'h79, P2 = 7'h24, P3 = 7'h30, P4 = 7'h19;
  localparam logic [6:0] P5 = 7'h12, P6 = 7'h02, P7 = 7'h78, P8 = 7'h00;
  localparam logic [6:0] BL = 7'h7F, BAD = 7'b1111110;
  always #5 clk = ~clk;
  seg_scan_decoder #(.SETTLE_CYC(4), .CONFIRM(2)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in), .dp_in(dp_in),
    .digit(digit), .blank(blank), .dp_seen(dp_seen),
    .frame_valid(frame_valid), .err_pattern(err_pattern), .err_anode(err_anode)
  );
  always @(negedge clk) begin
    if (frame_valid) fv_cnt += 1;
    if (err_pattern) ep_cnt += 1;
    if (err_anode) ea_cnt += 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    an_in = '1;
    seg_in = '1;
    dp_in = 1'b1;
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic show(input int s, input logic [6:0] p, input logic d, input int dwell);
    an_in = ~(4'b0001 << s);
    seg_in = p;
    dp_in = ~d;
    repeat (dwell) @(negedge clk);
  endtask
  task automatic scan(input logic [6:0] p3, p2, p1, p0, input logic [3:0] dpm, input int dwell);
    show(3, p3, dpm[3], dwell);
    show(2, p2, dpm[2], dwell);
    show(1, p1, dpm[1], dwell);
    show(0, p0, dpm[0], dwell);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
  endtask
  task automatic mark;
    fv0 = fv_cnt;
    ep0 = ep_cnt;
    ea0 = ea_cnt;
  endtask
  initial begin
    do_reset();
    check("rst_digit", 32'(digit), 32'hFFFF);
    check("rst_blank", 32'(blank), 32'hF);
    check("rst_dp", 32'(dp_seen), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_err", 32'({err_pattern, err_anode}), 32'h0);
    mark();
    scan(P1, P2, P3, P4, 4'b0100, 20);
    idle(4);
    check("s1_no_pub", 32'(fv_cnt - fv0), 32'd0);
    check("s1_digit", 32'(digit), 32'hFFFF);
    scan(P1, P2, P3, P4, 4'b0100, 20);
    idle(4);
    check("s2_pub", 32'(fv_cnt - fv0), 32'd1);
    check("s2_digit", 32'(digit), 32'h1234);
    check("s2_blank", 32'(blank), 32'h0);
    check("s2_dp", 32'(dp_seen), 32'h4);
    scan(P1, P2, P3, P4, 4'b0100, 20);
    idle(4);
    check("s3_no_repub", 32'(fv_cnt - fv0), 32'd1);
    check("s_no_errs", 32'((ep_cnt - ep0) + (ea_cnt - ea0)), 32'd0);
    do_reset();
    mark();
    repeat (3) scan(P1, P2, P3, P4, 4'hF, 3);
    idle(6);
    check("short_fv", 32'(fv_cnt - fv0), 32'd0);
    check("short_digit", 32'(digit), 32'hFFFF);
    check("short_blank", 32'(blank), 32'hF);
    check("short_dp", 32'(dp_seen), 32'h0);
    check("short_ep", 32'(ep_cnt - ep0), 32'd0);
    do_reset();
    mark();
    show(3, P1, 1'b0, 20);
    show(2, P2, 1'b0, 20);
    an_in = 4'b0011;
    @(negedge clk);
    show(1, P3, 1'b0, 20);
    show(0, P4, 1'b0, 20);
    idle(4);
    check("anode_err", 32'(ea_cnt - ea0), 32'd1);
    check("anode_discard", 32'(fv_cnt - fv0), 32'd0);
    scan(P1, P2, P3, P4, 4'b0000, 20);
    idle(4);
    check("anode_clean1", 32'(fv_cnt - fv0), 32'd0);
    scan(P1, P2, P3, P4, 4'b0000, 20);
    idle(4);
    check("anode_clean2", 32'(fv_cnt - fv0), 32'd1);
    check("anode_digit", 32'(digit), 32'h1234);
    do_reset();
    mark();
    repeat (2) scan(P1, P2, P3, P8, 4'b0000, 20);
    idle(4);
    check("pat8_digit", 32'(digit), 32'h1238);
    check("pat8_ep", 32'(ep_cnt - ep0), 32'd0);
    mark();
    repeat (2) scan(P1, P2, P3, BAD, 4'b0000, 20);
    idle(4);
    check("bad_digit", 32'(digit), 32'h123F);
    check("bad_blank", 32'(blank), 32'h0);
    check("bad_ep", 32'(ep_cnt - ep0), 32'd2);
    check("bad_fv", 32'(fv_cnt - fv0), 32'd1);
    do_reset();
    mark();
    repeat (2) scan(P0, P5, P1, P7, 4'b0100, 20);
    idle(4);
    check("blink_init", 32'(fv_cnt - fv0), 32'd1);
    check("blink_digit", 32'(digit), 32'h0517);
    mark();
    scan(BL, BL, P1, P7, 4'b0100, 20);
    scan(P0, P5, P1, P7, 4'b0100, 20);
    scan(BL, BL, P1, P7, 4'b0100, 20);
    scan(P0, P5, P1, P7, 4'b0100, 20);
    idle(4);
    check("blink_no_pub", 32'(fv_cnt - fv0), 32'd0);
    check("blink_hold", 32'({digit, blank}), 32'h05170);
    repeat (2) scan(BL, BL, P1, P7, 4'b0100, 20);
    idle(4);
    check("blank_pub", 32'(fv_cnt - fv0), 32'd1);
    check("blank_digit", 32'(digit), 32'hFF17);
    check("blank_flags", 32'(blank), 32'hC);
    check("blank_dp", 32'(dp_seen), 32'h4);
    do_reset();
    repeat (2) scan(P1, P2, P3, P4, 4'b0001, 20);
    idle(4);
    check("mid_pre", 32'(digit), 32'h1234);
    show(3, P5, 1'b0, 20);
    show(2, P6, 1'b0, 20);
    show(1, P7, 1'b0, 20);
    show(0, P8, 1'b0, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_digit", 32'(digit), 32'hFFFF);
    check("mid_blank", 32'(blank), 32'hF);
    check("mid_dp", 32'(dp_seen), 32'h0);
    mark();
    scan(P5, P6, P7, P8, 4'b0000, 20);
    idle(4);
    check("mid_scan1", 32'(fv_cnt - fv0), 32'd0);
    check("mid_scan1_digit", 32'(digit), 32'hFFFF);
    scan(P5, P6, P7, P8, 4'b0000, 20);
    idle(4);
    check("mid_scan2", 32'(fv_cnt - fv0), 32'd1);
    check("mid_scan2_digit", 32'(digit), 32'h5678);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
